simproc_ctrl_seq: RTL and testbench

//   Multicycle control sequencer for the simproc 8-bit accumulator datapath inside tt_um_ieeeuoftasic_simproc.

---
 rtl/simproc_ctrl_seq.sv | 196 +++++++++++++++++++
 tb/tb_simproc_ctrl_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/simproc_ctrl_seq.sv
// Multicycle control sequencer for the simproc accumulator datapath.
// Owns PC/IR, fetches over a req/ack port, decodes and drives datapath strobes.
module simproc_ctrl_seq #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              run,
  input  logic              step,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              dp_zero,
  output logic              dp_acc_we,
  output logic [1:0]        dp_alu_op,
  output logic [ADDR_W-1:0] dp_imm,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              fault,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDI = 3'b001;
  localparam logic [2:0] OP_LD  = 3'b010;
  localparam logic [2:0] OP_ST  = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_JZ  = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t              state_reg;
  logic [ADDR_W-1:0]   pc_reg;
  logic [DATA_W-1:0]   ir_reg;
  logic                step_latch_reg;
  logic [TW-1:0]       tmo_cnt_reg;
  logic                halted_reg;
  logic                fault_reg;

  logic [2:0]          opcode;
  logic [ADDR_W-1:0]   operand;
  logic                is_hlt;
  logic                is_mem_op;
  logic                tmo_hit;
  logic                cont;

  assign opcode    = ir_reg[DATA_W-1 -: 3];
  assign operand   = ir_reg[ADDR_W-1:0];
  assign is_hlt    = (opcode == OP_JMP) && (&operand);
  assign is_mem_op = (opcode == OP_LD) || (opcode == OP_ST) ||
                     (opcode == OP_ADD) || (opcode == OP_SUB);
  // An ack arriving in the same cycle the limit is reached takes priority.
  assign tmo_hit   = (TIMEOUT != 0) && !mem_ack && (tmo_cnt_reg == TW'(TIMEOUT - 1));
  assign cont      = run && !step_latch_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      pc_reg         <= '0;
      ir_reg         <= '0;
      step_latch_reg <= 1'b0;
      tmo_cnt_reg    <= '0;
      halted_reg     <= 1'b0;
      fault_reg      <= 1'b0;
    end else if (ena) begin
      case (state_reg)
        S_IDLE: begin
          tmo_cnt_reg <= '0;
          if (run) begin
            state_reg <= S_FETCH;
          end else if (step) begin
            state_reg      <= S_FETCH;
            step_latch_reg <= 1'b1;
          end
        end
        S_FETCH: begin
          if (mem_ack) begin
            ir_reg    <= mem_rdata;
            pc_reg    <= pc_reg + ADDR_W'(1);
            state_reg <= S_DECODE;
          end else if (tmo_hit) begin
            state_reg <= S_FAULT;
            fault_reg <= 1'b1;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
          end
        end
        S_DECODE: begin
          tmo_cnt_reg <= '0;
          if (is_hlt) begin
            state_reg  <= S_HALT;
            halted_reg <= 1'b1;
          end else if (is_mem_op) begin
            state_reg <= S_MEM;
          end else begin
            state_reg <= S_EXEC;
          end
        end
        S_EXEC: begin
          if ((opcode == OP_JMP) || ((opcode == OP_JZ) && dp_zero))
            pc_reg <= operand;
          tmo_cnt_reg <= '0;
          if (cont) begin
            state_reg <= S_FETCH;
          end else begin
            state_reg      <= S_IDLE;
            step_latch_reg <= 1'b0;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            tmo_cnt_reg <= '0;
            if (cont) begin
              state_reg <= S_FETCH;
            end else begin
              state_reg      <= S_IDLE;
              step_latch_reg <= 1'b0;
            end
          end else if (tmo_hit) begin
            state_reg <= S_FAULT;
            fault_reg <= 1'b1;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
          end
        end
        default: begin
          // HALT and FAULT are sticky until reset.
          state_reg <= state_reg;
        end
      endcase
    end
  end

  // Memory and datapath strobes decode the registered state; the load
  // strobe for memory operands must follow the ack in the same cycle.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    dp_acc_we = 1'b0;
    dp_alu_op = 2'b00;
    case (state_reg)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_reg;
      end
      S_EXEC: begin
        if (opcode == OP_LDI) dp_acc_we = 1'b1;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_addr = operand;
        mem_we   = (opcode == OP_ST);
        if (mem_ack && (opcode != OP_ST)) begin
          dp_acc_we = 1'b1;
          case (opcode)
            OP_LD:   dp_alu_op = 2'b01;
            OP_ADD:  dp_alu_op = 2'b10;
            OP_SUB:  dp_alu_op = 2'b11;
            default: dp_alu_op = 2'b00;
          endcase
        end
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  assign dp_imm = ir_reg[ADDR_W-1:0];
  assign pc     = pc_reg;
  assign halted = halted_reg;
  assign fault  = fault_reg;
  assign state  = state_reg;

  logic unused_nop;
  assign unused_nop = (OP_NOP == 3'b000);

endmodule

// File: tb/tb_simproc_ctrl_seq.sv
// Directed bench for simproc_ctrl_seq with a small req/ack memory model
// whose acknowledge latency is programmable per access.
module tb_simproc_ctrl_seq;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       run;
  logic       step;
  logic       mem_req;
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic       dp_zero;
  logic       dp_acc_we;
  logic [1:0] dp_alu_op;
  logic [4:0] dp_imm;
  logic [4:0] pc;
  logic       halted;
  logic       fault;
  logic [2:0] state;

  logic [7:0] mem [0:31];
  int         ack_delay;
  int         wait_cnt;
  int         checks;
  int         errors;
  int         req_seen;

  simproc_ctrl_seq #(.ADDR_W(5), .DATA_W(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .run(run), .step(step),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .dp_zero(dp_zero),
    .dp_acc_we(dp_acc_we), .dp_alu_op(dp_alu_op), .dp_imm(dp_imm),
    .pc(pc), .halted(halted), .fault(fault), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack after ack_delay wait cycles of a held request.
  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = mem_req && (wait_cnt >= ack_delay);

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    step = 1'b0;
    ack_delay = 0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    wait_cnt = 0;
    ena = 1'b1;
    dp_zero = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    @(negedge clk);

    // 1: LDI 5 then NOP under run
    mem[0] = 8'h25;
    mem[1] = 8'h00;
    do_reset();
    chk("rst_state", state, 0);
    chk("rst_pc", pc, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_imm", dp_imm, 0);
    chk("rst_flags", {halted, fault, dp_acc_we}, 0);
    run = 1'b1;
    cyc(1);
    chk("t1_fetch", {state, mem_req, mem_addr, mem_ack}, {3'd1, 1'b1, 5'd0, 1'b1});
    cyc(1);
    chk("t1_decode", {state, pc, dp_acc_we}, {3'd2, 5'd1, 1'b0});
    cyc(1);
    chk("t1_ldi", {state, dp_acc_we, dp_alu_op, dp_imm}, {3'd3, 1'b1, 2'b00, 5'd5});
    cyc(3);
    chk("t1_pc2", {state, pc, dp_acc_we}, {3'd3, 5'd2, 1'b0});
    run = 1'b0;
    cyc(1);
    chk("t1_idle", {state, pc}, {3'd0, 5'd2});

    // 2: ADD 0x10 with 4 wait cycles
    mem[0] = 8'h90;
    do_reset();
    run = 1'b1;
    cyc(2);
    ack_delay = 4;
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk($sformatf("t2_wait%0d", i), {state, mem_req, mem_we, mem_addr, mem_ack, dp_acc_we},
          {3'd4, 1'b1, 1'b0, 5'h10, 1'b0, 1'b0});
    end
    cyc(1);
    chk("t2_ack", {state, mem_req, mem_addr, mem_ack, dp_acc_we, dp_alu_op},
        {3'd4, 1'b1, 5'h10, 1'b1, 1'b1, 2'b10});
    cyc(1);
    chk("t2_done", {state, mem_req, dp_acc_we}, {3'd0, 1'b0, 1'b0});

    // 3: single-step
    mem[0] = 8'h00;
    mem[1] = 8'h00;
    do_reset();
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    chk("t3_fetch", state, 1);
    cyc(3);
    chk("t3_step1", {state, pc}, {3'd0, 5'd1});
    cyc(3);
    chk("t3_hold", {state, pc, mem_req}, {3'd0, 5'd1, 1'b0});
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    cyc(3);
    chk("t3_step2", {state, pc}, {3'd0, 5'd2});

    // 4: JZ taken, JZ not taken, JMP, pc wrap
    mem[0]    = 8'hDA;
    mem[5'h1A] = 8'hD5;
    mem[5'h1B] = 8'hFE;
    mem[5'h1E] = 8'h00;
    mem[5'h1F] = 8'h00;
    do_reset();
    dp_zero = 1'b1;
    run = 1'b1;
    cyc(4);
    chk("t4_jz_taken", {state, mem_addr}, {3'd1, 5'h1A});
    cyc(1);
    dp_zero = 1'b0;
    cyc(2);
    chk("t4_jz_not", {state, mem_addr}, {3'd1, 5'h1B});
    cyc(6);
    chk("t4_fetch1f", {state, mem_addr}, {3'd1, 5'h1F});
    cyc(1);
    chk("t4_wrap", {state, pc}, {3'd2, 5'd0});
    run = 1'b0;
    cyc(2);
    chk("t4_idle", state, 0);

    // 5: HLT is sticky
    mem[0] = 8'hFF;
    do_reset();
    run = 1'b1;
    cyc(3);
    chk("t5_halt", {state, halted, fault}, {3'd5, 1'b1, 1'b0});
    req_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step = i[0];
      cyc(1);
      if (mem_req) req_seen++;
    end
    step = 1'b0;
    chk("t5_noreq", req_seen, 0);
    chk("t5_still", {state, halted}, {3'd5, 1'b1});
    rst_n = 1'b0;
    cyc(1);
    chk("t5_rst", {state, halted}, {3'd0, 1'b0});
    rst_n = 1'b1;

    // 6a: LD with no ack -> fault 15 cycles after req rises
    mem[0] = 8'h45;
    do_reset();
    run = 1'b1;
    cyc(2);
    ack_delay = 1000;
    cyc(1);
    chk("t6_req", {state, mem_req, mem_addr}, {3'd4, 1'b1, 5'd5});
    cyc(14);
    chk("t6_prefault", {state, mem_req, fault}, {3'd4, 1'b1, 1'b0});
    cyc(1);
    chk("t6_fault", {state, mem_req, fault}, {3'd6, 1'b0, 1'b1});
    cyc(3);
    chk("t6_sticky", {state, fault, mem_req}, {3'd6, 1'b1, 1'b0});

    // 6b: ack on the very cycle the limit is reached wins
    do_reset();
    chk("t6b_rst", {state, fault}, {3'd0, 1'b0});
    run = 1'b1;
    cyc(2);
    ack_delay = 14;
    run = 1'b0;
    cyc(15);
    chk("t6b_ack", {state, mem_ack, dp_acc_we, dp_alu_op, fault}, {3'd4, 1'b1, 1'b1, 2'b01, 1'b0});
    cyc(1);
    chk("t6b_idle", {state, fault}, {3'd0, 1'b0});

    // 6c: ST, reset mid-MEM drops the request
    mem[0] = 8'h67;
    do_reset();
    run = 1'b1;
    cyc(2);
    ack_delay = 1000;
    cyc(1);
    chk("t6c_st", {state, mem_req, mem_we, mem_addr}, {3'd4, 1'b1, 1'b1, 5'd7});
    cyc(3);
    rst_n = 1'b0;
    cyc(1);
    chk("t6c_rst", {state, mem_req, mem_we, pc}, {3'd0, 1'b0, 1'b0, 5'd0});
    rst_n = 1'b1;
    run = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
